// File: rtl/sd_cmd_engine_if.sv
`default_nettype none
// ============================================================================
// sd_cmd_engine_if : CMD-line pad and card-logic signals of the SD CMD engine
// Revision: 1.0
// ============================================================================
interface sd_cmd_engine_if;
  logic         cmd_i;
  logic         cmd_o;
  logic         cmd_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_crc_err;
  logic         resp_ready;
  logic         resp_valid;
  logic [1:0]   resp_type;
  logic [5:0]   resp_index;
  logic [127:0] resp_payload;

  modport slave (
    input  cmd_i, resp_valid, resp_type, resp_index, resp_payload,
    output cmd_o, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready
  );

  modport master (
    output cmd_i, resp_valid, resp_type, resp_index, resp_payload,
    input  cmd_o, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc_err, resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// sd_cmd_engine : card-side SD CMD-line receiver/responder with CRC7
// Revision: 1.0
// ============================================================================
module sd_cmd_engine #(
  parameter int NCR_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 64,
  parameter bit R2_EN        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  sd_cmd_engine_if.slave  bus
);

  localparam int              c_CW      = $clog2(RESP_TIMEOUT + 2) + 1;
  localparam logic [c_CW-1:0] c_NCR     = c_CW'(NCR_CYCLES);
  localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_SEND  = 3'd5
  } state_t;

  function automatic logic [6:0] f_crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Init is zero, so leading zero bits leave the CRC untouched: shorter
  // fields are zero-extended on the left and share this one function.
  function automatic logic [6:0] f_crc7(input logic [119:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 119; i >= 0; i--) c = f_crc_step(c, d[i]);
    return c;
  endfunction

  state_t            r_state, w_next;
  logic [5:0]        r_rcnt;
  logic [44:0]       r_shift;
  logic [6:0]        r_crc;
  logic [c_CW-1:0]   r_ecnt;
  logic [135:0]      r_tx;
  logic [7:0]        r_txcnt;
  logic              r_long;
  logic              r_cmd_o, r_cmd_oe, r_crc_err;
  logic [5:0]        r_cmd_index;
  logic [31:0]       r_cmd_arg;

  logic w_ready, w_hs, w_short, w_long, w_accept, w_err, w_ncr_ok;
  logic [6:0] w_crc_short, w_crc_long;

  assign w_ready     = ((r_state == S_CHECK) && !r_crc_err) || (r_state == S_WAIT);
  assign w_hs        = bus.resp_valid && w_ready;
  assign w_short     = (bus.resp_type == 2'd1);
  assign w_long      = R2_EN && (bus.resp_type == 2'd2);
  assign w_accept    = w_short || w_long;
  assign w_err       = (r_shift[6:0] != r_crc) || !bus.cmd_i;
  assign w_ncr_ok    = (r_ecnt >= c_NCR);
  assign w_crc_short = f_crc7({80'd0, 2'b00, bus.resp_index, bus.resp_payload[31:0]});
  assign w_crc_long  = f_crc7(bus.resp_payload[127:8]);

  assign bus.cmd_o       = r_cmd_o;
  assign bus.cmd_oe      = r_cmd_oe;
  assign bus.cmd_valid   = (r_state == S_CHECK);
  assign bus.cmd_index   = r_cmd_index;
  assign bus.cmd_arg     = r_cmd_arg;
  assign bus.cmd_crc_err = r_crc_err;
  assign bus.resp_ready  = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_rcnt == 6'd1) w_next = bus.cmd_i ? S_RECV : S_IDLE;
      S_RECV:  if (r_rcnt == 6'd47) w_next = S_CHECK;
      S_CHECK, S_WAIT: begin
        if (w_hs)
          w_next = w_accept ? S_GAP : S_IDLE;
        else if (((r_state == S_CHECK) && r_crc_err) || (r_ecnt == c_TIMEOUT))
          w_next = S_IDLE;
        else
          w_next = S_WAIT;
      end
      S_GAP:   if (w_ncr_ok) w_next = S_SEND;
      S_SEND:  if (r_txcnt == 8'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt      <= 6'd0;
      r_shift     <= '0;
      r_crc       <= 7'd0;
      r_ecnt      <= '0;
      r_tx        <= '0;
      r_txcnt     <= 8'd0;
      r_long      <= 1'b0;
      r_cmd_o     <= 1'b1;
      r_cmd_oe    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_cmd_index <= 6'd0;
      r_cmd_arg   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rcnt == 6'd0) begin
            if (!bus.cmd_i) begin
              r_rcnt <= 6'd1;
              r_crc  <= f_crc_step(7'd0, 1'b0);
            end
          end else if (bus.cmd_i) begin
            r_rcnt <= 6'd2;
            r_crc  <= f_crc_step(r_crc, 1'b1);
          end else begin
            // Transmission bit 0: another device's response, not a command.
            r_rcnt <= 6'd0;
            r_crc  <= 7'd0;
          end
        end
        S_RECV: begin
          r_shift <= {r_shift[43:0], bus.cmd_i};
          r_rcnt  <= r_rcnt + 6'd1;
          if (r_rcnt < 6'd40) r_crc <= f_crc_step(r_crc, bus.cmd_i);
          if (r_rcnt == 6'd47) begin
            r_cmd_index <= r_shift[44:39];
            r_cmd_arg   <= r_shift[38:7];
            r_crc_err   <= w_err;
            r_ecnt      <= {{(c_CW-1){1'b0}}, 1'b1};
            r_rcnt      <= 6'd0;
            r_crc       <= 7'd0;
          end
        end
        S_CHECK, S_WAIT: begin
          r_ecnt <= r_ecnt + 1'b1;
          if (w_hs && w_long) begin
            r_tx   <= {2'b00, 6'h3F, bus.resp_payload[127:8], w_crc_long, 1'b1};
            r_long <= 1'b1;
          end else if (w_hs && w_short) begin
            r_tx   <= {2'b00, bus.resp_index, bus.resp_payload[31:0], w_crc_short, 1'b1, 88'd0};
            r_long <= 1'b0;
          end
        end
        S_GAP: begin
          r_ecnt <= r_ecnt + 1'b1;
          if (w_ncr_ok) begin
            r_cmd_oe <= 1'b1;
            r_cmd_o  <= r_tx[135];
            r_tx     <= {r_tx[134:0], 1'b0};
            r_txcnt  <= r_long ? 8'd135 : 8'd47;
          end
        end
        S_SEND: begin
          if (r_txcnt == 8'd0) begin
            r_cmd_oe <= 1'b0;
            r_cmd_o  <= 1'b1;
          end else begin
            r_cmd_o  <= r_tx[135];
            r_tx     <= {r_tx[134:0], 1'b0};
            r_txcnt  <= r_txcnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// tb_sd_cmd_engine : directed self-checking bench for sd_cmd_engine
// Revision: 1.0
// ============================================================================
module tb_sd_cmd_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_cmd_engine_if bus();

  sd_cmd_engine #(
    .NCR_CYCLES  (2),
    .RESP_TIMEOUT(64),
    .R2_EN       (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int e_cyc    = 0;

  localparam logic [127:0] c_CSD = 128'h400E0032_5B590000_3B377F80_0A4040AF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'b0001001;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_model({80'd0, h}, 40), 1'b1};
  endfunction

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_i = f[i];
      tick();
    end
    bus.cmd_i = 1'b1;
    e_cyc = cyc;
  endtask

  task automatic handshake(input int k, input logic [1:0] t, input logic [5:0] idx,
                           input logic [127:0] p);
    bus.resp_type    = t;
    bus.resp_index   = idx;
    bus.resp_payload = p;
    for (int j = 1; j < k; j++) tick();
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
  endtask

  task automatic capture(output int st, output int len, output logic [135:0] bits);
    st = -1; len = 0; bits = '0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (bus.cmd_oe === 1'b1) begin
        if (len == 0) st = cyc;
        bits = {bits[134:0], bus.cmd_o};
        len++;
      end else if (len > 0) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.cmd_oe !== 1'b0) begin failures++; $display("FAIL reset_cmd_oe actual=%0h expected=0", bus.cmd_oe); end
    checks++; if (bus.cmd_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_o actual=%0h expected=1", bus.cmd_o); end
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid actual=%0h expected=0", bus.cmd_valid); end
    checks++; if (bus.resp_ready !== 1'b0) begin failures++; $display("FAIL reset_resp_ready actual=%0h expected=0", bus.resp_ready); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL reset_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL reset_cmd_index actual=%0h expected=0", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL reset_cmd_arg actual=%0h expected=0", bus.cmd_arg); end
  endtask

  task automatic test_cmd0_no_resp();
    int oe_seen, v_seen;
    send_cmd(48'h40_00000000_95);
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL cmd0_valid actual=%0h expected=1", bus.cmd_valid); end
    checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL cmd0_index actual=%0h expected=0", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL cmd0_arg actual=%0h expected=0", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL cmd0_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    checks++; if (bus.resp_ready !== 1'b1) begin failures++; $display("FAIL cmd0_ready_rise actual=%0h expected=1", bus.resp_ready); end
    handshake(1, 2'd0, 6'd0, 128'd0);
    checks++; if (bus.resp_ready !== 1'b0) begin failures++; $display("FAIL cmd0_ready_fall actual=%0h expected=0", bus.resp_ready); end
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL cmd0_valid_once actual=%0h expected=0", bus.cmd_valid); end
    oe_seen = 0; v_seen = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (bus.cmd_oe !== 1'b0) oe_seen++;
      if (bus.cmd_valid !== 1'b0) v_seen++;
    end
    checks++; if (oe_seen != 0) begin failures++; $display("FAIL cmd0_no_drive actual=%0d expected=0", oe_seen); end
    checks++; if (v_seen != 0) begin failures++; $display("FAIL cmd0_no_extra_valid actual=%0d expected=0", v_seen); end
  endtask

  task automatic test_cmd8_back_to_back();
    int st, len;
    logic [135:0] bits;
    send_cmd(48'h48_000001AA_87);
    checks++; if (bus.cmd_index !== 6'd8) begin failures++; $display("FAIL cmd8_index actual=%0h expected=8", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'h1AA) begin failures++; $display("FAIL cmd8_arg actual=%0h expected=1aa", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL cmd8_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    handshake(1, 2'd1, 6'd8, 128'h1AA);
    checks++; if (bus.cmd_oe !== 1'b0) begin failures++; $display("FAIL cmd8_oe_at_hs actual=%0h expected=0", bus.cmd_oe); end
    capture(st, len, bits);
    checks++; if (st != e_cyc + 2) begin failures++; $display("FAIL cmd8_start_edge actual=%0d expected=%0d", st - e_cyc, 2); end
    checks++; if (len != 48) begin failures++; $display("FAIL cmd8_len actual=%0d expected=48", len); end
    checks++; if (bits[47:0] !== 48'h08_000001AA_13) begin failures++; $display("FAIL cmd8_frame actual=%012h expected=08000001aa13", bits[47:0]); end
    checks++; if (bus.cmd_o !== 1'b1) begin failures++; $display("FAIL cmd8_idle_o actual=%0h expected=1", bus.cmd_o); end
    send_cmd(48'h77_00000000_65);
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid actual=%0h expected=1", bus.cmd_valid); end
    checks++; if (bus.cmd_index !== 6'd55) begin failures++; $display("FAIL b2b_index actual=%0d expected=55", bus.cmd_index); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL b2b_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    handshake(1, 2'd0, 6'd0, 128'd0);
  endtask

  task automatic test_crc_err();
    int rdy_seen, oe_seen;
    send_cmd(48'h40_00000000_97);
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL err_valid actual=%0h expected=1", bus.cmd_valid); end
    checks++; if (bus.cmd_crc_err !== 1'b1) begin failures++; $display("FAIL err_flag actual=%0h expected=1", bus.cmd_crc_err); end
    checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL err_index actual=%0d expected=0", bus.cmd_index); end
    bus.resp_type = 2'd1; bus.resp_valid = 1'b1;
    rdy_seen = (bus.resp_ready !== 1'b0) ? 1 : 0;
    oe_seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.resp_ready !== 1'b0) rdy_seen++;
      if (bus.cmd_oe !== 1'b0) oe_seen++;
    end
    bus.resp_valid = 1'b0;
    checks++; if (rdy_seen != 0) begin failures++; $display("FAIL err_no_ready actual=%0d expected=0", rdy_seen); end
    checks++; if (oe_seen != 0) begin failures++; $display("FAIL err_no_drive actual=%0d expected=0", oe_seen); end
    send_cmd(48'h77_00000000_65);
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL cmd55_valid actual=%0h expected=1", bus.cmd_valid); end
    checks++; if (bus.cmd_index !== 6'd55) begin failures++; $display("FAIL cmd55_index actual=%0d expected=55", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL cmd55_arg actual=%0h expected=0", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL cmd55_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    handshake(1, 2'd0, 6'd0, 128'd0);
  endtask

  task automatic test_r2();
    int st, len;
    logic [135:0] bits;
    logic [119:0] body;
    body = c_CSD[127:8];
    send_cmd(make_cmd(6'd9, 32'h0001_0000));
    checks++; if (bus.cmd_index !== 6'd9) begin failures++; $display("FAIL cmd9_index actual=%0d expected=9", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'h0001_0000) begin failures++; $display("FAIL cmd9_arg actual=%0h expected=10000", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL cmd9_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    bus.resp_type = 2'd2; bus.resp_index = 6'd9; bus.resp_payload = c_CSD;
    for (int j = 1; j < 10; j++) tick();
    checks++; if (bus.resp_ready !== 1'b1) begin failures++; $display("FAIL cmd9_ready_held actual=%0h expected=1", bus.resp_ready); end
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    checks++; if (bus.resp_ready !== 1'b0) begin failures++; $display("FAIL cmd9_ready_fall actual=%0h expected=0", bus.resp_ready); end
    capture(st, len, bits);
    checks++; if (st != e_cyc + 11) begin failures++; $display("FAIL r2_start_edge actual=%0d expected=11", st - e_cyc); end
    checks++; if (len != 136) begin failures++; $display("FAIL r2_len actual=%0d expected=136", len); end
    checks++; if (bits[135:128] !== 8'h3F) begin failures++; $display("FAIL r2_header actual=%02h expected=3f", bits[135:128]); end
    checks++; if (bits[127:8] !== body) begin failures++; $display("FAIL r2_body actual=%030h expected=%030h", bits[127:8], body); end
    checks++; if (bits[7:1] !== crc7_model(body, 120)) begin failures++; $display("FAIL r2_crc actual=%02h expected=%02h", bits[7:1], crc7_model(body, 120)); end
    checks++; if (bits[0] !== 1'b1) begin failures++; $display("FAIL r2_end_bit actual=%0h expected=1", bits[0]); end
  endtask

  task automatic test_timeout();
    int oe_seen;
    send_cmd(make_cmd(6'd13, 32'h0001_0000));
    for (int j = 1; j < 64; j++) tick();
    checks++; if (bus.resp_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready_e63 actual=%0h expected=1", bus.resp_ready); end
    tick();
    checks++; if (bus.resp_ready !== 1'b0) begin failures++; $display("FAIL tmo_ready_e64 actual=%0h expected=0", bus.resp_ready); end
    bus.resp_type = 2'd1; bus.resp_index = 6'd13; bus.resp_payload = 128'h900;
    bus.resp_valid = 1'b1;
    oe_seen = 0;
    for (int t = 0; t < 70; t++) begin
      tick();
      if (t == 5) bus.resp_valid = 1'b0;
      if (bus.cmd_oe !== 1'b0) oe_seen++;
    end
    checks++; if (oe_seen != 0) begin failures++; $display("FAIL tmo_late_valid_ignored actual=%0d expected=0", oe_seen); end
    send_cmd(make_cmd(6'd17, 32'h1234_5678));
    checks++; if (bus.cmd_index !== 6'd17) begin failures++; $display("FAIL tmo_next_index actual=%0d expected=17", bus.cmd_index); end
    checks++; if (bus.cmd_arg !== 32'h1234_5678) begin failures++; $display("FAIL tmo_next_arg actual=%0h expected=12345678", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL tmo_next_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    handshake(1, 2'd0, 6'd0, 128'd0);
  endtask

  task automatic test_reset_mid_send();
    send_cmd(48'h48_000001AA_87);
    handshake(1, 2'd1, 6'd8, 128'h1AA);
    for (int t = 0; t < 20 && bus.cmd_oe !== 1'b1; t++) tick();
    checks++; if (bus.cmd_oe !== 1'b1) begin failures++; $display("FAIL rst_send_started actual=%0h expected=1", bus.cmd_oe); end
    for (int t = 0; t < 19; t++) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.cmd_oe !== 1'b0) begin failures++; $display("FAIL rst_async_oe actual=%0h expected=0", bus.cmd_oe); end
    checks++; if (bus.cmd_o !== 1'b1) begin failures++; $display("FAIL rst_async_o actual=%0h expected=1", bus.cmd_o); end
    tick(); tick();
    #3 rst = 1'b0;
    tick(); tick();
    send_cmd(48'h40_00000000_95);
    checks++; if (bus.cmd_valid !== 1'b1) begin failures++; $display("FAIL rst_cmd0_valid actual=%0h expected=1", bus.cmd_valid); end
    checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL rst_cmd0_arg actual=%0h expected=0", bus.cmd_arg); end
    checks++; if (bus.cmd_crc_err !== 1'b0) begin failures++; $display("FAIL rst_cmd0_crc_err actual=%0h expected=0", bus.cmd_crc_err); end
    handshake(1, 2'd0, 6'd0, 128'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.cmd_i        = 1'b1;
    bus.resp_valid   = 1'b0;
    bus.resp_type    = 2'd0;
    bus.resp_index   = 6'd0;
    bus.resp_payload = 128'd0;
    tick(); tick(); tick();
    test_reset();
    #3 rst = 1'b0;
    tick(); tick();
    test_cmd0_no_resp();
    test_cmd8_back_to_back();
    test_crc_err();
    test_r2();
    test_timeout();
    test_reset_mid_send();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
